weight_serializer: RTL and testbench

WEIGHT_SERIALIZER -- requirements
Module: weight_serializer

---
 rtl/weight_serializer.sv | 90 +++++++++
 tb/tb_weight_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/weight_serializer.sv
// rtl/weight_serializer.sv - serialises host weight words MSB-first into a bit-serial weight RAM
// Handshake in WAIT, WIDTH-cycle write burst in SHIFT, one-cycle Done after the last word.
module weight_serializer #(
  parameter int WIDTH  = 10,
  parameter int NWORDS = 65,
  parameter int AW     = 7
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic             wValid,
  input  logic [WIDTH-1:0] wData,
  output logic             wReady,
  output logic             In,
  output logic             WE,
  output logic [AW-1:0]    Addr,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bcnt;
  logic [AW-1:0]    addr;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      addr  <= '0;
    end else if (Abort) begin
      // Abort outranks every other transition and never produces Done
      state <= ST_IDLE;
      bcnt  <= '0;
      addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state <= ST_WAIT;
            addr  <= '0;
          end
        end
        ST_WAIT: begin
          if (wValid) begin
            sreg  <= wData;
            bcnt  <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg <= sreg << 1;
          if (bcnt == LAST_BIT) begin
            bcnt <= '0;
            if (addr == LAST_ADDR) begin
              state <= ST_DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_WAIT;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so Rst clears them without a clock
  assign wReady = (state == ST_WAIT);
  assign WE     = (state == ST_SHIFT);
  assign In     = (state == ST_SHIFT) & sreg[WIDTH-1];
  assign Addr   = addr;
  assign Busy   = (state != ST_IDLE);
  assign Done   = (state == ST_DONE);

endmodule

// File: tb/tb_weight_serializer.sv
// tb/tb_weight_serializer.sv - directed self-checking bench for weight_serializer
module tb_weight_serializer;

  localparam int WIDTH  = 10;
  localparam int NWORDS = 65;
  localparam int AW     = 7;

  logic             Clock = 1'b0;
  logic             Rst = 1'b1;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic             wValid = 1'b0;
  logic [WIDTH-1:0] wData = '0;
  logic             wReady;
  logic             In;
  logic             WE;
  logic [AW-1:0]    Addr;
  logic             Busy;
  logic             Done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  weight_serializer #(.WIDTH(WIDTH), .NWORDS(NWORDS), .AW(AW)) dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .Abort(Abort),
    .wValid(wValid), .wData(wData), .wReady(wReady), .In(In),
    .WE(WE), .Addr(Addr), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (Done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in"}, 32'(In), 0);
    check({tag, "_we"}, 32'(WE), 0);
    check({tag, "_addr"}, 32'(Addr), 0);
    check({tag, "_wready"}, 32'(wReady), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
  endtask

  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat2;
  int d0, cycles, we_cnt, bad_in, bad_addr, done_addr;

  initial begin
    // reset state
    #1;
    check_all_zero("reset");
    step(2);
    Rst = 1'b0;
    step(2);
    check("idle_after_reset_busy", 32'(Busy), 0);

    // single word, with Start/wValid noise during the burst
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("wait_busy", 32'(Busy), 1);
    check("wait_wready", 32'(wReady), 1);
    check("wait_addr", 32'(Addr), 0);
    check("wait_we", 32'(WE), 0);
    pat = 10'b1011001110;
    wValid = 1'b1;
    wData = pat;
    step();
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("w0_we_%0d", i), 32'(WE), 1);
      check($sformatf("w0_in_%0d", i), 32'(In), 32'(pat[WIDTH-1-i]));
      check($sformatf("w0_addr_%0d", i), 32'(Addr), 0);
      check($sformatf("w0_wready_%0d", i), 32'(wReady), 0);
      if (i == 0) begin
        Start = 1'b1;
        wData = '0;
      end
      step();
    end
    check("w0_end_wready", 32'(wReady), 1);
    check("w0_end_we", 32'(WE), 0);
    check("w0_end_addr", 32'(Addr), 1);
    Start = 1'b0;
    wValid = 1'b0;

    // stall in WAIT
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_wready_%0d", i), 32'(wReady), 1);
      check($sformatf("stall_we_%0d", i), 32'(WE), 0);
      check($sformatf("stall_addr_%0d", i), 32'(Addr), 1);
    end

    // abort at bit 4 of word 20
    wValid = 1'b1;
    wData = 10'h2A5;
    step(1 + 19 * (WIDTH + 1) + 4);
    check("abort_pre_addr", 32'(Addr), 20);
    check("abort_pre_we", 32'(WE), 1);
    d0 = done_cnt;
    Abort = 1'b1;
    Start = 1'b1;
    step();
    Abort = 1'b0;
    Start = 1'b0;
    wValid = 1'b0;
    check("abort_busy", 32'(Busy), 0);
    check("abort_we", 32'(WE), 0);
    check("abort_addr", 32'(Addr), 0);
    check("abort_wready", 32'(wReady), 0);
    step(3);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("abort_restart_addr", 32'(Addr), 0);
    check("abort_restart_wready", 32'(wReady), 1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("abort_idle_again", 32'(Busy), 0);

    // full back-to-back load
    d0 = done_cnt;
    pat2 = 10'b1100110101;
    wData = pat2;
    wValid = 1'b1;
    Start = 1'b1;
    cycles = 0;
    we_cnt = 0;
    bad_in = 0;
    bad_addr = 0;
    done_addr = -1;
    while (cycles < 2000) begin
      step();
      Start = 1'b0;
      cycles++;
      if (WE) begin
        if (In !== pat2[WIDTH-1-(we_cnt % WIDTH)]) bad_in++;
        if (32'(Addr) != 32'(we_cnt / WIDTH)) bad_addr++;
        we_cnt++;
      end
      if (Done) done_addr = 32'(Addr);
      if (!Busy) break;
    end
    wValid = 1'b0;
    check("full_cycles", 32'(cycles), 1 + NWORDS * (WIDTH + 1) + 1);
    check("full_we_cycles", 32'(we_cnt), NWORDS * WIDTH);
    check("full_bad_in", 32'(bad_in), 0);
    check("full_bad_addr", 32'(bad_addr), 0);
    check("full_done_pulses", 32'(done_cnt - d0), 1);
    check("full_done_addr", 32'(done_addr), NWORDS - 1);

    // reset mid-burst at word 7
    wValid = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    step(1 + 7 * (WIDTH + 1) + 3);
    check("rst_pre_addr", 32'(Addr), 7);
    check("rst_pre_we", 32'(WE), 1);
    #2 Rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    #3 Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_after_we_%0d", i), 32'(WE), 0);
      check($sformatf("rst_after_busy_%0d", i), 32'(Busy), 0);
    end
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("rst_restart_addr", 32'(Addr), 0);
    check("rst_restart_wready", 32'(wReady), 1);
    step();
    check("rst_restart_latency_we", 32'(WE), 1);
    check("rst_restart_latency_addr", 32'(Addr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
